// File: rtl/multichannel_sample_ring.sv
// multichannel_sample_ring: per-channel circular history of the last DEPTH samples,
// written through a tagged port and read back by (channel, age) with one cycle of latency.
// Optional feature macro: RUNNING_SUM_EN adds a per-channel running sum and the rd_sum port.

module multichannel_sample_ring #(
  parameter  int NUM_CHANNELS = 7,
  parameter  int SAMPLE_W     = 8,
  parameter  int DEPTH        = 10,
  localparam int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int IDX_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W        = $clog2(DEPTH + 1),
  localparam int SUM_W        = SAMPLE_W + $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_valid,
  input  logic [CH_W-1:0]     wr_chan,
  input  logic [SAMPLE_W-1:0] wr_data,
  input  logic                clr_valid,
  input  logic [CH_W-1:0]     clr_chan,
  input  logic                rd_valid,
  input  logic [CH_W-1:0]     rd_chan,
  input  logic [IDX_W-1:0]    rd_age,
  output logic [SAMPLE_W-1:0] rd_data,
  output logic                rd_hit,
  output logic                rd_done,
  output logic [CNT_W-1:0]    rd_count,
  output logic                wr_err
`ifdef RUNNING_SUM_EN
  ,
  output logic [SUM_W-1:0]    rd_sum
`endif
);

  localparam logic [CH_W:0]    NCH_X    = (CH_W + 1)'(NUM_CHANNELS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [IDX_W:0]   DEPTH_X  = (IDX_W + 1)'(DEPTH);

  logic [SAMPLE_W-1:0] mem [NUM_CHANNELS][DEPTH];
  logic [IDX_W-1:0]    wr_ptr  [NUM_CHANNELS];
  logic [CNT_W-1:0]    count   [NUM_CHANNELS];
  logic [IDX_W-1:0]    ptr_nxt [NUM_CHANNELS];
  logic [CNT_W-1:0]    cnt_nxt [NUM_CHANNELS];

  logic                wr_ok, wr_go, clr_go, rd_ok;
  logic [IDX_W-1:0]    wr_slot;
  logic [CNT_W-1:0]    rd_cnt_sel;
  logic                rd_hit_nxt;
  logic [IDX_W:0]      rd_ptr_x, rd_back;
  logic [IDX_W-1:0]    rd_idx;
  logic [SAMPLE_W-1:0] rd_data_nxt;

  // Channel validity, write slot and read address decode
  always_comb begin
    wr_ok      = {1'b0, wr_chan} < NCH_X;
    wr_go      = wr_valid && wr_ok;
    clr_go     = clr_valid && ({1'b0, clr_chan} < NCH_X);
    rd_ok      = {1'b0, rd_chan} < NCH_X;
    // A same-cycle clear of the written channel rewinds the write to slot 0
    wr_slot    = (clr_go && (clr_chan == wr_chan)) ? '0 : wr_ptr[wr_chan];
    rd_cnt_sel = rd_ok ? count[rd_chan] : '0;
    rd_hit_nxt = rd_ok && (CNT_W'(rd_age) < rd_cnt_sel);
    // Slot = (wr_ptr - 1 - age) mod DEPTH, wrapped explicitly in IDX_W+1 bits
    rd_ptr_x   = {1'b0, wr_ptr[rd_chan]};
    rd_back    = {1'b0, rd_age} + 1'b1;
    rd_idx     = (rd_ptr_x >= rd_back) ? IDX_W'(rd_ptr_x - rd_back)
                                       : IDX_W'(rd_ptr_x + DEPTH_X - rd_back);
    rd_data_nxt = rd_hit_nxt ? mem[rd_chan][rd_idx] : '0;
  end

  // Per-channel pointer and fill update: clear first, then write on top of it
  always_comb begin
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      ptr_nxt[c] = wr_ptr[c];
      cnt_nxt[c] = count[c];
      if (clr_go && (clr_chan == CH_W'(c))) begin
        ptr_nxt[c] = '0;
        cnt_nxt[c] = '0;
      end
      if (wr_go && (wr_chan == CH_W'(c))) begin
        ptr_nxt[c] = (ptr_nxt[c] == LAST_IDX) ? '0 : ptr_nxt[c] + 1'b1;
        if (cnt_nxt[c] != FULL_CNT) cnt_nxt[c] = cnt_nxt[c] + 1'b1;
      end
    end
  end

  // Per-channel state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
        wr_ptr[c] <= '0;
        count[c]  <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
        wr_ptr[c] <= ptr_nxt[c];
        count[c]  <= cnt_nxt[c];
      end
    end
  end

  // Sample storage, deliberately unreset; rd_hit gates every read of it
  always_ff @(posedge clk) begin
    if (wr_go) mem[wr_chan][wr_slot] <= wr_data;
  end

  // Registered read response and write-error pulse, from pre-update state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_hit   <= 1'b0;
      rd_done  <= 1'b0;
      rd_count <= '0;
      wr_err   <= 1'b0;
    end else begin
      rd_done <= rd_valid;
      wr_err  <= wr_valid && !wr_ok;
      if (rd_valid) begin
        rd_data  <= rd_data_nxt;
        rd_hit   <= rd_hit_nxt;
        rd_count <= rd_cnt_sel;
      end
    end
  end

`ifdef RUNNING_SUM_EN
  logic [SUM_W-1:0] sum     [NUM_CHANNELS];
  logic [SUM_W-1:0] sum_nxt [NUM_CHANNELS];

  // Running sum: add the new sample, drop the overwritten one when the buffer was full
  always_comb begin
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      sum_nxt[c] = sum[c];
      if (clr_go && (clr_chan == CH_W'(c))) sum_nxt[c] = '0;
      if (wr_go && (wr_chan == CH_W'(c))) begin
        sum_nxt[c] = sum_nxt[c] + SUM_W'(wr_data)
                   - ((!(clr_go && (clr_chan == CH_W'(c))) && (count[c] == FULL_CNT))
                      ? SUM_W'(mem[c][wr_ptr[c]]) : '0);
      end
    end
  end

  // Sum registers and the registered rd_sum readout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) sum[c] <= '0;
      rd_sum <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) sum[c] <= sum_nxt[c];
      if (rd_valid) rd_sum <= rd_ok ? sum[rd_chan] : '0;
    end
  end
`endif

endmodule

// File: tb/tb_multichannel_sample_ring.sv
// tb_multichannel_sample_ring: table-driven directed vectors, a reset-mid-stream sequence,
// and randomized traffic checked against an age-ordered history model.
// Build with RUNNING_SUM_EN defined to exercise rd_sum as well.

module tb_multichannel_sample_ring;

  localparam int NCH = 7;
  localparam int D   = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_valid, clr_valid, rd_valid;
  logic [2:0] wr_chan, clr_chan, rd_chan;
  logic [7:0] wr_data;
  logic [3:0] rd_age;
  logic [7:0] rd_data;
  logic       rd_hit, rd_done, wr_err;
  logic [3:0] rd_count;
`ifdef RUNNING_SUM_EN
  logic [11:0] rd_sum;
`endif

  multichannel_sample_ring #(.NUM_CHANNELS(NCH), .SAMPLE_W(8), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_chan(wr_chan), .wr_data(wr_data),
    .clr_valid(clr_valid), .clr_chan(clr_chan),
    .rd_valid(rd_valid), .rd_chan(rd_chan), .rd_age(rd_age),
    .rd_data(rd_data), .rd_hit(rd_hit), .rd_done(rd_done), .rd_count(rd_count),
    .wr_err(wr_err)
`ifdef RUNNING_SUM_EN
    , .rd_sum(rd_sum)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: hist[c][a] is the sample of age a (0 = newest), cnt[c] how many exist
  logic [7:0] hist [NCH][D];
  int         cnt  [NCH];
  logic       m_done, m_hit, m_err;
  logic [7:0] m_data;
  logic [3:0] m_count;
  logic [11:0] m_sum;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) cnt[c] = 0;
    m_done = 0; m_hit = 0; m_err = 0; m_data = 0; m_count = 0; m_sum = 0;
  endtask

  task automatic model_step(input logic wv, input int wc, input logic [7:0] wd,
                            input logic cv, input int cc,
                            input logic rv, input int rc, input int ra);
    int s;
    m_done = rv;
    m_err  = wv && (wc >= NCH);
    if (rv) begin
      if (rc < NCH) begin
        m_count = 4'(cnt[rc]);
        m_hit   = ra < cnt[rc];
        m_data  = m_hit ? hist[rc][ra] : 8'h00;
        s = 0;
        for (int a = 0; a < cnt[rc]; a++) s += int'(hist[rc][a]);
        m_sum = 12'(s);
      end else begin
        m_count = 0; m_hit = 0; m_data = 0; m_sum = 0;
      end
    end
    if (cv && cc < NCH) cnt[cc] = 0;
    if (wv && wc < NCH) begin
      for (int a = D - 1; a > 0; a--) hist[wc][a] = hist[wc][a-1];
      hist[wc][0] = wd;
      if (cnt[wc] < D) cnt[wc]++;
    end
  endtask

  // Drive one cycle of inputs, advance the model, and sample just after the edge
  task automatic step(input logic wv, input int wc, input logic [7:0] wd,
                      input logic cv, input int cc,
                      input logic rv, input int rc, input int ra);
    wr_valid = wv; wr_chan = 3'(wc); wr_data = wd;
    clr_valid = cv; clr_chan = 3'(cc);
    rd_valid = rv; rd_chan = 3'(rc); rd_age = 4'(ra);
    model_step(wv, wc, wd, cv, cc, rv, rc, ra);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       wv; int wc; logic [7:0] wd;
    logic       cv; int cc;
    logic       rv; int rc; int ra;
    logic       e_hit; logic [7:0] e_data; logic [3:0] e_cnt; logic e_err; logic [11:0] e_sum;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic wv, input int wc, input logic [7:0] wd,
                              input logic cv, input int cc,
                              input logic rv, input int rc, input int ra,
                              input logic eh, input logic [7:0] ed, input logic [3:0] en,
                              input logic ee, input logic [11:0] es);
    vec_t v;
    v.wv = wv; v.wc = wc; v.wd = wd; v.cv = cv; v.cc = cc;
    v.rv = rv; v.rc = rc; v.ra = ra;
    v.e_hit = eh; v.e_data = ed; v.e_cnt = en; v.e_err = ee; v.e_sum = es;
    tbl.push_back(v);
  endfunction

  function automatic void wr(input int c, input logic [7:0] d);
    add(1, c, d, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic void rd(input int c, input int a, input logic h, input logic [7:0] d,
                             input logic [3:0] n, input logic [11:0] s);
    add(0, 0, 0, 0, 0, 1, c, a, h, d, n, 0, s);
  endfunction

  initial begin
    rst_n = 0;
    wr_valid = 0; wr_chan = 0; wr_data = 0;
    clr_valid = 0; clr_chan = 0; rd_valid = 0; rd_chan = 0; rd_age = 0;
    model_reset();

    // Reset and read of an empty channel
    rd(0, 0, 0, 8'h00, 0, 0);
    // Fill ch2 past capacity: retains 3..12
    for (int i = 1; i <= 12; i++) wr(2, 8'(i));
    rd(2, 0,  1, 8'd12, 10, 75);
    rd(2, 9,  1, 8'd3,  10, 75);
    rd(2, 10, 0, 8'd0,  10, 75);
    // Same fill on ch1, then clear it
    for (int i = 1; i <= 12; i++) wr(1, 8'(i));
    rd(1, 0, 1, 8'd12, 10, 75);
    add(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    rd(1, 0, 0, 8'd0, 0, 0);
    // Highest channel, channel 0, and an out-of-range write
    wr(6, 8'hAA);
    wr(0, 8'h55);
    add(1, 7, 8'h99, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    rd(6, 0, 1, 8'hAA, 1, 170);
    rd(0, 0, 1, 8'h55, 1, 85);
    rd(3, 0, 0, 8'h00, 0, 0);
    rd(4, 0, 0, 8'h00, 0, 0);
    rd(5, 0, 0, 8'h00, 0, 0);
    // Read-before-write on ch3
    wr(3, 8'h31); wr(3, 8'h32); wr(3, 8'h33);
    add(1, 3, 8'h77, 0, 0, 1, 3, 0, 1, 8'h33, 3, 0, 150);
    rd(3, 0, 1, 8'h77, 4, 269);
    rd(3, 3, 1, 8'h31, 4, 269);
    rd(3, 4, 0, 8'h00, 4, 269);
    // Clear and write ch2 in one cycle
    add(1, 2, 8'h10, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    rd(2, 0, 1, 8'h10, 1, 16);
    rd(2, 1, 0, 8'h00, 1, 16);
    // Read sees the pre-clear state
    add(0, 0, 0, 1, 6, 1, 6, 0, 1, 8'hAA, 1, 0, 170);
    rd(6, 0, 0, 8'h00, 0, 0);
    // Invalid read channel; invalid clear is ignored
    rd(7, 0, 0, 8'h00, 0, 0);
    add(0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    rd(0, 0, 1, 8'h55, 1, 85);
    // Pointer wrap on ch5
    for (int i = 0; i < 10; i++) wr(5, 8'(8'h50 + i));
    rd(5, 9, 1, 8'h50, 10, 845);
    wr(5, 8'h5A);
    rd(5, 9, 1, 8'h51, 10, 855);
    rd(5, 0, 1, 8'h5A, 10, 855);

    #12;
    chk("reset rd_data", 32'(rd_data), 0);
    chk("reset rd_hit", 32'(rd_hit), 0);
    chk("reset rd_done", 32'(rd_done), 0);
    chk("reset rd_count", 32'(rd_count), 0);
    chk("reset wr_err", 32'(wr_err), 0);
    @(negedge clk);
    rst_n = 1;

    foreach (tbl[i]) begin
      step(tbl[i].wv, tbl[i].wc, tbl[i].wd, tbl[i].cv, tbl[i].cc,
           tbl[i].rv, tbl[i].rc, tbl[i].ra);
      chk($sformatf("vec%0d rd_done", i), 32'(rd_done), 32'(tbl[i].rv));
      chk($sformatf("vec%0d wr_err", i), 32'(wr_err), 32'(tbl[i].e_err));
      if (tbl[i].rv) begin
        chk($sformatf("vec%0d rd_hit", i), 32'(rd_hit), 32'(tbl[i].e_hit));
        chk($sformatf("vec%0d rd_data", i), 32'(rd_data), 32'(tbl[i].e_data));
        chk($sformatf("vec%0d rd_count", i), 32'(rd_count), 32'(tbl[i].e_cnt));
`ifdef RUNNING_SUM_EN
        chk($sformatf("vec%0d rd_sum", i), 32'(rd_sum), 32'(tbl[i].e_sum));
`endif
      end
    end

    // Asynchronous reset in the middle of activity
    step(1, 4, 8'h42, 0, 0, 0, 0, 0);
    step(1, 7, 8'h01, 0, 0, 1, 4, 0);
    chk("pre-rst rd_data", 32'(rd_data), 32'h42);
    chk("pre-rst wr_err", 32'(wr_err), 1);
    #2;
    rst_n = 0;
    #1;
    chk("async rst rd_data", 32'(rd_data), 0);
    chk("async rst rd_hit", 32'(rd_hit), 0);
    chk("async rst rd_done", 32'(rd_done), 0);
    chk("async rst rd_count", 32'(rd_count), 0);
    chk("async rst wr_err", 32'(wr_err), 0);
`ifdef RUNNING_SUM_EN
    chk("async rst rd_sum", 32'(rd_sum), 0);
`endif
    model_reset();
    @(negedge clk);
    rst_n = 1;
    step(0, 0, 0, 0, 0, 1, 4, 0);
    chk("post-rst ch4 hit", 32'(rd_hit), 0);
    chk("post-rst ch4 count", 32'(rd_count), 0);

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      logic wv, cv, rv;
      int wc, cc, rc, ra;
      wv = ($urandom_range(0, 9) < 7);
      cv = ($urandom_range(0, 19) == 0);
      rv = ($urandom_range(0, 9) < 7);
      wc = $urandom_range(0, 7);
      cc = $urandom_range(0, 7);
      rc = $urandom_range(0, 7);
      ra = $urandom_range(0, 15);
      step(wv, wc, 8'($urandom), cv, cc, rv, rc, ra);
      chk("rnd rd_done", 32'(rd_done), 32'(m_done));
      chk("rnd wr_err", 32'(wr_err), 32'(m_err));
      chk("rnd rd_hit", 32'(rd_hit), 32'(m_hit));
      chk("rnd rd_data", 32'(rd_data), 32'(m_data));
      chk("rnd rd_count", 32'(rd_count), 32'(m_count));
`ifdef RUNNING_SUM_EN
      chk("rnd rd_sum", 32'(rd_sum), 32'(m_sum));
`endif
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
